// File: rtl/uart_hex_tx_sequencer.sv
// uart_hex_tx_sequencer
// Queues bytes from a UART receiver and echoes each one to a UART transmitter
// as two uppercase ASCII hex characters (high nibble first), optionally
// followed by CR, LF.
//
// Parameters
//   FIFO_DEPTH : receive-byte queue depth, power of two in 2..16
//   SEND_CRLF  : 1 = append 0x0D 0x0A after the hex pair, 0 = hex pair only
//
// Ports
//   i_clk, i_rst_n : rising-edge clock, asynchronous active-low reset
//   i_rx_byte      : received byte, qualified by the one-cycle i_rx_valid strobe
//   o_tx_byte      : character for the transmitter, held between pulses
//   o_tx_dv        : one-cycle transmit-start pulse
//   i_tx_active    : transmitter busy
//   i_tx_done      : one-cycle strobe at the end of the transmitter stop bit
//   o_busy         : sequencer is working on a byte (FSM not in IDLE)
//   o_overflow     : sticky, a received byte was dropped because the queue was full
//   o_fifo_count   : number of bytes waiting in the queue
module uart_hex_tx_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SEND_CRLF  = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [7:0]                    i_rx_byte,
    input  logic                          i_rx_valid,
    output logic [7:0]                    o_tx_byte,
    output logic                          o_tx_dv,
    input  logic                          i_tx_active,
    input  logic                          i_tx_done,
    output logic                          o_busy,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0]  LAST_IDX = (SEND_CRLF != 0) ? 2'd3 : 2'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ISSUE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    // Upper-case ASCII hex digit for one nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
    endfunction

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow_q;

    state_t        state;
    logic [1:0]    idx;
    logic [7:0]    cur_byte;
    logic [7:0]    tx_byte_q;
    logic          busy_q;

    logic          fifo_full;
    logic          pop;
    logic          push;
    logic [7:0]    issue_char;

    // The only pop happens in LOAD, which is entered only with a non-empty queue.
    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign pop       = (state == S_LOAD);
    // A write at full is still accepted when the head leaves in the same cycle.
    assign push      = i_rx_valid && (!fifo_full || pop);

    // Character selected by the current index.
    always_comb begin
        issue_char = 8'h0A;
        case (idx)
            2'd0:    issue_char = hex_char(cur_byte[7:4]);
            2'd1:    issue_char = hex_char(cur_byte[3:0]);
            2'd2:    issue_char = 8'h0D;
            default: issue_char = 8'h0A;
        endcase
    end

    // The start pulse must appear in the first ISSUE cycle once the transmitter
    // is free, so it is decoded from the state register and i_tx_active.
    assign o_tx_dv      = (state == S_ISSUE) && !i_tx_active;
    assign o_tx_byte    = o_tx_dv ? issue_char : tx_byte_q;
    assign o_busy       = busy_q;
    assign o_overflow   = overflow_q;
    assign o_fifo_count = count;

    // Queue storage; contents need no reset because the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_rx_byte;
        end
    end

    // Queue pointers, occupancy and sticky overflow. Pointers wrap naturally
    // because FIFO_DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            if (i_rx_valid && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Sequencer FSM: fetch a byte, then issue its characters one per transmit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            idx       <= 2'd0;
            cur_byte  <= 8'h00;
            tx_byte_q <= 8'h00;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        state  <= S_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    cur_byte <= mem[rd_ptr];
                    idx      <= 2'd0;
                    state    <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!i_tx_active) begin
                        tx_byte_q <= issue_char;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_tx_done) begin
                        if (idx == LAST_IDX) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_tx_sequencer.sv
// Bench for uart_hex_tx_sequencer: one instance with CR/LF enabled driven by a
// small transmitter model, and one hex-only instance driven by hand.
module tb_uart_hex_tx_sequencer;

    localparam int TXLEN  = 6;
    localparam int NO_CHK = -1;
    localparam int FOLLOW = -2;

    typedef struct {
        logic [7:0] data;
        int         exp_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       tx_active;
    logic       tx_done;
    logic       hold_active;
    logic [7:0] tx_byte;
    logic       tx_dv;
    logic       busy;
    logic       overflow;
    logic [2:0] fifo_count;

    logic [7:0] rx_byte0;
    logic       rx_valid0;
    logic       tx_active0;
    logic       tx_done0;
    logic [7:0] tx_byte0;
    logic       tx_dv0;
    logic       busy0;
    logic       overflow0;
    logic [2:0] fifo_count0;

    uart_hex_tx_sequencer #(.FIFO_DEPTH(4), .SEND_CRLF(1)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_byte    (rx_byte),
        .i_rx_valid   (rx_valid),
        .o_tx_byte    (tx_byte),
        .o_tx_dv      (tx_dv),
        .i_tx_active  (tx_active | hold_active),
        .i_tx_done    (tx_done),
        .o_busy       (busy),
        .o_overflow   (overflow),
        .o_fifo_count (fifo_count)
    );

    uart_hex_tx_sequencer #(.FIFO_DEPTH(4), .SEND_CRLF(0)) dut0 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_byte    (rx_byte0),
        .i_rx_valid   (rx_valid0),
        .o_tx_byte    (tx_byte0),
        .o_tx_dv      (tx_dv0),
        .i_tx_active  (tx_active0),
        .i_tx_done    (tx_done0),
        .o_busy       (busy0),
        .o_overflow   (overflow0),
        .o_fifo_count (fifo_count0)
    );

    exp_t exp_q[$];
    exp_t exp0_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   pulses = 0;
    int   pulses0 = 0;
    int   last_done = -100;
    int   prev_dv = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] nib);
        string h;
        h = "0123456789ABCDEF";
        return h[nib];
    endfunction

    task automatic push_exp(input logic [7:0] d, input int c);
        exp_t e;
        e.data    = d;
        e.exp_cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic expect_byte(input logic [7:0] b, input int first_cyc);
        push_exp(hexc(b[7:4]), first_cyc);
        push_exp(hexc(b[3:0]), FOLLOW);
        push_exp(8'h0D, FOLLOW);
        push_exp(8'h0A, FOLLOW);
    endtask

    task automatic goto_cycle(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || fifo_count != 3'd0) && n < max) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < max), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Transmitter model: busy for TXLEN cycles after each start pulse, then done.
    initial begin
        int cnt;
        int seen;
        cnt = 0;
        seen = 0;
        tx_active = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (!rst_n) begin
                cnt = 0;
                tx_active = 1'b0;
                seen = pulses;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    tx_active = 1'b0;
                    tx_done = 1'b1;
                end
            end else if (pulses != seen) begin
                seen = pulses;
                tx_active = 1'b1;
                cnt = TXLEN;
            end
        end
    end

    // Monitor for the CR/LF instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_done) last_done = cyc;
            if (tx_dv) begin
                pulses++;
                check("dv_while_tx_active", 32'(tx_active | hold_active), 32'd0);
                check("dv_width", 32'(prev_dv == cyc - 1), 32'd0);
                prev_dv = cyc;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_dv: got byte 0x%0h at cycle %0d, expected no pulse", tx_byte, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", 32'(tx_byte), 32'(e.data));
                    if (e.exp_cyc == FOLLOW)
                        check("dv_after_done", 32'(cyc), 32'(last_done + 1));
                    else if (e.exp_cyc >= 0)
                        check("dv_cycle", 32'(cyc), 32'(e.exp_cyc));
                end
            end
        end
    end

    // Monitor for the hex-only instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_dv0) begin
                pulses0++;
                if (exp0_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_dv0: got byte 0x%0h at cycle %0d, expected no pulse", tx_byte0, cyc);
                end else begin
                    e = exp0_q.pop_front();
                    check("tx_byte0", 32'(tx_byte0), 32'(e.data));
                    check("dv0_cycle", 32'(cyc), 32'(e.exp_cyc));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int base;
        int t0;
        exp_t e;

        rst_n = 1'b0;
        rx_byte = 8'h00;
        rx_valid = 1'b0;
        hold_active = 1'b0;
        rx_byte0 = 8'h00;
        rx_valid0 = 1'b0;
        tx_active0 = 1'b0;
        tx_done0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        check("rst_tx_dv", 32'(tx_dv), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 0x3A -> "3A\r\n", first pulse three cycles after the strobe
        t0 = cyc;
        push_exp(8'h33, t0 + 3);
        push_exp(8'h41, FOLLOW);
        push_exp(8'h0D, FOLLOW);
        push_exp(8'h0A, FOLLOW);
        strobe(8'h3A);
        wait_drain("drain_3a", 300);

        // Overflow: 0x11 in flight, then 0x22..0x66 back to back; 0x66 dropped
        t0 = cyc;
        expect_byte(8'h11, t0 + 3);
        expect_byte(8'h22, NO_CHK);
        expect_byte(8'h33, NO_CHK);
        expect_byte(8'h44, NO_CHK);
        expect_byte(8'h55, NO_CHK);
        strobe(8'h11);
        goto_cycle(t0 + 3);
        strobe(8'h22);
        strobe(8'h33);
        strobe(8'h44);
        strobe(8'h55);
        strobe(8'h66);
        @(negedge clk);
        check("ovf_fifo_count", 32'(fifo_count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        @(posedge clk);
        #1;
        wait_drain("drain_overflow", 1500);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Transmitter busy for 10 cycles on ISSUE entry
        hold_active = 1'b1;
        t0 = cyc;
        push_exp(8'h35, t0 + 13);
        push_exp(8'h43, FOLLOW);
        push_exp(8'h0D, FOLLOW);
        push_exp(8'h0A, FOLLOW);
        strobe(8'h5C);
        goto_cycle(t0 + 5);
        @(negedge clk);
        check("stall_byte_held", 32'(tx_byte), 32'h0A);
        check("stall_dv_low", 32'(tx_dv), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        goto_cycle(t0 + 13);
        hold_active = 1'b0;
        wait_drain("drain_stall", 300);

        // Reset between the 2nd and 3rd character with two bytes queued
        t0 = cyc;
        base = pulses;
        expect_byte(8'h7E, t0 + 3);
        expect_byte(8'h81, NO_CHK);
        strobe(8'h7E);
        strobe(8'h81);
        n = 0;
        while (pulses < base + 2 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("two_chars_before_reset", 32'(pulses - base), 32'd2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_tx_dv", 32'(tx_dv), 32'd0);
        check("midrst_tx_byte", 32'(tx_byte), 32'h00);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_fifo_count", 32'(fifo_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = pulses;
        repeat (100) @(posedge clk);
        #1;
        check("no_dv_after_reset", 32'(pulses - base), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_fifo_count", 32'(fifo_count), 32'd0);

        // Write at full coincident with the LOAD pop
        t0 = cyc;
        expect_byte(8'h01, t0 + 3);
        expect_byte(8'hA1, NO_CHK);
        expect_byte(8'hA2, NO_CHK);
        expect_byte(8'hA3, NO_CHK);
        expect_byte(8'hA4, NO_CHK);
        expect_byte(8'hA5, NO_CHK);
        strobe(8'h01);
        goto_cycle(t0 + 3);
        strobe(8'hA1);
        strobe(8'hA2);
        strobe(8'hA3);
        strobe(8'hA4);
        @(negedge clk);
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_no_overflow", 32'(overflow), 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 300);
        check("idle_before_load", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("load_busy", 32'(busy), 32'd1);
        check("load_count", 32'(fifo_count), 32'd4);
        strobe(8'hA5);
        check("coinc_count", 32'(fifo_count), 32'd4);
        check("coinc_overflow", 32'(overflow), 32'd0);
        wait_drain("drain_coinc", 1500);

        // Hex-only instance: 0xF0 -> 0x46, 0x30, then idle
        t0 = cyc;
        e.data = 8'h46;
        e.exp_cyc = t0 + 3;
        exp0_q.push_back(e);
        rx_byte0 = 8'hF0;
        rx_valid0 = 1'b1;
        @(posedge clk);
        #1;
        rx_valid0 = 1'b0;
        goto_cycle(t0 + 4);
        tx_active0 = 1'b1;
        goto_cycle(t0 + 8);
        tx_active0 = 1'b0;
        tx_done0 = 1'b1;
        e.data = 8'h30;
        e.exp_cyc = t0 + 9;
        exp0_q.push_back(e);
        goto_cycle(t0 + 9);
        tx_done0 = 1'b0;
        goto_cycle(t0 + 10);
        tx_active0 = 1'b1;
        goto_cycle(t0 + 14);
        tx_active0 = 1'b0;
        tx_done0 = 1'b1;
        @(negedge clk);
        check("crlf0_busy_at_done", 32'(busy0), 32'd1);
        @(posedge clk);
        #1;
        tx_done0 = 1'b0;
        @(negedge clk);
        check("crlf0_idle_after_done", 32'(busy0), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("crlf0_pulse_count", 32'(pulses0), 32'd2);
        check("exp0_q_empty", 32'(exp0_q.size()), 32'd0);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_hex_tx_sequencer.md
UART_HEX_TX_SEQUENCER -- requirements
Module: uart_hex_tx_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: receive-byte queue depth; power of two, 2..16.
REQ-002 SHALL have parameter SEND_CRLF, default 1: 1 = append CR, LF after the two hex characters; 0 = hex characters only.
REQ-003 SHALL have port i_clk  input  1: sole clock; all logic on the rising edge.
REQ-004 SHALL have port i_rst_n  input  1: asynchronous reset, active low.
REQ-005 SHALL have port i_rx_byte  input  8: received byte from the UART receiver.
REQ-006 SHALL have port i_rx_valid  input  1: one-cycle strobe; i_rx_byte is valid in that cycle.
REQ-007 SHALL have port o_tx_byte  output  8: character presented to the UART transmitter.
REQ-008 SHALL have port o_tx_dv  output  1: one-cycle transmit-start pulse to the transmitter.
REQ-009 SHALL have port i_tx_active  input  1: transmitter busy.
REQ-010 SHALL have port i_tx_done  input  1: one-cycle strobe at the end of the transmitter stop bit.
REQ-011 SHALL have port o_busy  output  1: high whenever the FSM is not in IDLE.
REQ-012 SHALL have port o_overflow  output  1: sticky flag; a received byte was dropped.
REQ-013 SHALL have port o_fifo_count  output  $clog2(FIFO_DEPTH)+1: number of bytes queued.

Function
REQ-014 SHALL convert each queued byte to uppercase ASCII hex, high nibble first: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
REQ-015 SHALL transmit characters in order HI, LO, then 0x0D, 0x0A when SEND_CRLF=1, so each byte sends 4 characters (2 when SEND_CRLF=0).
REQ-016 SHALL write i_rx_byte into the FIFO on every i_rx_valid cycle when the FIFO is not full.
REQ-017 SHALL accept the write when the FIFO is full and a pop occurs in the same cycle; o_fifo_count SHALL then stay unchanged.
REQ-018 SHALL drop the byte and set o_overflow when i_rx_valid arrives at full with no pop in the same cycle; o_overflow clears only on reset.
REQ-019 SHALL use a 4-state FSM: IDLE, LOAD, ISSUE, WAIT, plus a 2-bit character index idx.
REQ-020 IDLE: SHALL go to LOAD when o_fifo_count != 0.
REQ-021 LOAD: SHALL pop the FIFO head into the current-byte register, set idx=0, and go to ISSUE next cycle.
REQ-022 ISSUE: SHALL, when i_tx_active=0, drive o_tx_byte=char(idx) and o_tx_dv=1 for exactly one cycle, then go to WAIT.
REQ-023 ISSUE: SHALL hold o_tx_dv=0 and stay in ISSUE while i_tx_active=1.
REQ-024 WAIT: SHALL, on i_tx_done, go to IDLE if idx is the last index (3, or 1 when SEND_CRLF=0); otherwise increment idx and go to ISSUE.
REQ-025 WAIT: SHALL ignore i_tx_done in any other state, and never issue o_tx_dv while in WAIT.
REQ-026 SHALL hold o_tx_byte at its last issued value between pulses.
REQ-027 Latency: when i_rx_valid arrives in cycle N into an empty FIFO with the FSM in IDLE, SHALL be in LOAD at N+2 and assert o_tx_dv in N+3, provided i_tx_active=0.
REQ-028 Next-character o_tx_dv SHALL occur one cycle after the i_tx_done cycle when i_tx_active=0.
REQ-029 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; o_fifo_count SHALL never exceed FIFO_DEPTH.
REQ-030 SHALL allow FIFO writes in all FSM states, including while a byte is being transmitted.

Reset
REQ-031 SHALL, on i_rst_n low, immediately set: FSM=IDLE, idx=0, FIFO empty (pointers 0), o_fifo_count=0, o_tx_dv=0, o_tx_byte=0x00, o_busy=0, o_overflow=0.
REQ-032 SHALL, on reset asserted mid-character, abandon the current byte and all queued bytes; no o_tx_dv after reset release until a new i_rx_valid.

Verification
REQ-033 SHALL cover: SEND_CRLF=1, i_rx_byte=0x3A strobe -> o_tx_dv pulses carry 0x33, 0x41, 0x0D, 0x0A in order; each pulse is one cycle wide and follows the prior i_tx_done by one cycle; first pulse is 3 cycles after the strobe.
REQ-034 SHALL cover: SEND_CRLF=0, byte 0xF0 -> exactly two pulses, 0x46 then 0x30; FSM returns to IDLE and o_busy=0 the cycle after the second i_tx_done.
REQ-035 SHALL cover: FIFO_DEPTH=4; send 0x11; after LOAD, strobe 0x22, 0x33, 0x44, 0x55, 0x66 back to back -> o_fifo_count=4, o_overflow=1, 0x66 never transmitted; output is "11","22","33","44","55" each followed by CRLF.
REQ-036 SHALL cover: FIFO full and i_rx_valid coincident with LOAD pop -> byte accepted, o_fifo_count stays 4, o_overflow stays 0.
REQ-037 SHALL cover: i_tx_active held high for 10 cycles on ISSUE entry -> o_tx_dv stays 0 throughout, then pulses in the cycle after i_tx_active falls.
REQ-038 SHALL cover: i_rst_n pulsed low between the 2nd and 3rd character, with 2 bytes queued -> all outputs at REQ-031 values immediately, and no o_tx_dv for 100 cycles after release.
